// File: rtl/control_frame_stack.sv
// control_frame_stack
// -------------------
// WebAssembly control-frame stack (block / loop / if / call) that sits between
// the instruction decoder and the operand stack.
//
// Every frame records its type, continuation PC, operand-stack height at
// entry and result arity. The top frame's entry height becomes the operand
// stack's underflow_limit. POP and BRANCH resolve a frame into a target
// PC / height / arity, which the operand stack and PC unit consume.
//
// Handshake: a request is taken on a rising clk edge when op_valid && ready.
// ready is high only in IDLE. A request raised while ready is low is not
// queued, so upstream keeps op_valid and its operands steady until ready
// returns.
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   op_valid, op     request strobe and opcode (0 NONE, 1 PUSH, 2 POP, 3 BRANCH)
//   frame_type       0 BLOCK, 1 LOOP, 2 IF, 3 CALL (used by PUSH)
//   frame_pc         continuation PC stored with the frame
//   frame_height     operand-stack index at frame entry
//   frame_arity      frame yields one result
//   br_depth         relative label index for BRANCH
//   ready            request can be taken this cycle
//   depth            live frame count
//   underflow_limit  top frame height (0 when empty)
//   top_type         top frame type (0 when empty)
//   target_valid     one-cycle pulse carrying target_pc/height/arity
//   status           0 NONE, 1 EMPTY, 2 FULL, 3 UNDERFLOW, 4 OVERFLOW, 5 BAD_OFFSET
module control_frame_stack #(
   parameter int PC_WIDTH     = 16,
   parameter int HEIGHT_WIDTH = 8,
   parameter int DEPTH        = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    op_valid,
   input  logic [1:0]              op,
   input  logic [1:0]              frame_type,
   input  logic [PC_WIDTH-1:0]     frame_pc,
   input  logic [HEIGHT_WIDTH-1:0] frame_height,
   input  logic                    frame_arity,
   input  logic [DEPTH-1:0]        br_depth,
   output logic                    ready,
   output logic [DEPTH:0]          depth,
   output logic [HEIGHT_WIDTH-1:0] underflow_limit,
   output logic [1:0]              top_type,
   output logic                    target_valid,
   output logic [PC_WIDTH-1:0]     target_pc,
   output logic [HEIGHT_WIDTH-1:0] target_height,
   output logic                    target_arity,
   output logic [2:0]              status
);

   localparam int MAX_FRAMES = 1 << DEPTH;
   localparam logic [DEPTH:0] FULL_COUNT = (DEPTH + 1)'(MAX_FRAMES);
   localparam logic [DEPTH:0] COUNT_ONE  = (DEPTH + 1)'(1);
   localparam logic [DEPTH:0] COUNT_ZERO = '0;

   localparam logic [1:0] OP_NONE   = 2'd0;
   localparam logic [1:0] OP_PUSH   = 2'd1;
   localparam logic [1:0] OP_POP    = 2'd2;
   localparam logic [1:0] OP_BRANCH = 2'd3;

   localparam logic [1:0] TYPE_LOOP = 2'd1;

   localparam logic [2:0] ST_NONE       = 3'd0;
   localparam logic [2:0] ST_EMPTY      = 3'd1;
   localparam logic [2:0] ST_FULL       = 3'd2;
   localparam logic [2:0] ST_UNDERFLOW  = 3'd3;
   localparam logic [2:0] ST_OVERFLOW   = 3'd4;
   localparam logic [2:0] ST_BAD_OFFSET = 3'd5;

   typedef enum logic {
      S_IDLE,
      S_RESOLVE
   } state_t;

   typedef struct packed {
      logic [1:0]              ftype;
      logic [PC_WIDTH-1:0]     pc;
      logic [HEIGHT_WIDTH-1:0] height;
      logic                    arity;
   } frame_t;

   frame_t mem [MAX_FRAMES];

   state_t                  state, state_n;
   logic [DEPTH:0]          depth_n;
   logic [2:0]              status_n;
   logic [HEIGHT_WIDTH-1:0] limit_n;
   logic [1:0]              top_type_n;
   logic                    tvalid_n;
   logic [PC_WIDTH-1:0]     tpc_n;
   logic [HEIGHT_WIDTH-1:0] theight_n;
   logic                    tarity_n;
   logic [DEPTH-1:0]        br_reg, br_reg_n;
   logic                    loop_reg, loop_reg_n;

   logic                    wr_en;
   logic                    upd_top;
   frame_t                  wr_frame;
   frame_t                  pop_frame;
   frame_t                  br_frame;
   frame_t                  top_frame;
   logic [DEPTH:0]          br_ext;
   logic [DEPTH:0]          pop_pos;
   logic [DEPTH:0]          br_pos;
   logic [DEPTH:0]          top_pos;

   function automatic logic [2:0] status_for(input logic [DEPTH:0] d);
      if (d == FULL_COUNT)      return ST_FULL;
      else if (d == COUNT_ZERO) return ST_EMPTY;
      else                      return ST_NONE;
   endfunction

   assign ready    = (state == S_IDLE);
   assign wr_frame = '{ftype: frame_type, pc: frame_pc, height: frame_height, arity: frame_arity};
   assign br_ext   = {1'b0, br_depth};
   assign pop_pos  = depth - COUNT_ONE;
   assign br_pos   = depth - COUNT_ONE - br_ext;
   // POP reads the top entry and BRANCH its label entry; both are captured
   // into the target registers on the accepting edge, so the pulse appears
   // one cycle later.
   assign pop_frame = mem[pop_pos[DEPTH-1:0]];
   assign br_frame  = mem[br_pos[DEPTH-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n    = state;
      depth_n    = depth;
      status_n   = status;
      tvalid_n   = 1'b0;
      tpc_n      = target_pc;
      theight_n  = target_height;
      tarity_n   = target_arity;
      br_reg_n   = br_reg;
      loop_reg_n = loop_reg;
      wr_en      = 1'b0;
      upd_top    = 1'b0;

      case (state)
         S_IDLE: begin
            if (op_valid) begin
               case (op)
                  OP_NONE: status_n = status_for(depth);
                  OP_PUSH: begin
                     if (depth == FULL_COUNT) begin
                        status_n = ST_OVERFLOW;
                     end else begin
                        wr_en    = 1'b1;
                        depth_n  = depth + COUNT_ONE;
                        status_n = status_for(depth_n);
                        upd_top  = 1'b1;
                     end
                  end
                  OP_POP: begin
                     if (depth == COUNT_ZERO) begin
                        status_n = ST_UNDERFLOW;
                     end else begin
                        depth_n   = pop_pos;
                        status_n  = status_for(depth_n);
                        upd_top   = 1'b1;
                        tvalid_n  = 1'b1;
                        tpc_n     = pop_frame.pc;
                        theight_n = pop_frame.height;
                        tarity_n  = pop_frame.arity;
                     end
                  end
                  default: begin // OP_BRANCH
                     if (br_ext >= depth) begin
                        status_n = ST_BAD_OFFSET;
                     end else begin
                        state_n    = S_RESOLVE;
                        br_reg_n   = br_depth;
                        loop_reg_n = (br_frame.ftype == TYPE_LOOP);
                        tvalid_n   = 1'b1;
                        tpc_n      = br_frame.pc;
                        theight_n  = br_frame.height;
                        // A branch to a loop re-enters it, so nothing is carried.
                        tarity_n   = (br_frame.ftype == TYPE_LOOP) ? 1'b0 : br_frame.arity;
                     end
                  end
               endcase
            end
         end
         default: begin // S_RESOLVE
            state_n = S_IDLE;
            // The loop frame itself survives a branch to it; any other
            // target frame is closed together with everything above it.
            if (loop_reg) depth_n = depth - {1'b0, br_reg};
            else          depth_n = depth - COUNT_ONE - {1'b0, br_reg};
            status_n = status_for(depth_n);
            upd_top  = 1'b1;
         end
      endcase

      // New top frame. A PUSH writes the memory on the same edge, so its
      // frame comes straight from the inputs.
      top_pos = depth_n - COUNT_ONE;
      if (wr_en) top_frame = wr_frame;
      else       top_frame = mem[top_pos[DEPTH-1:0]];

      limit_n    = underflow_limit;
      top_type_n = top_type;
      if (upd_top) begin
         if (depth_n == COUNT_ZERO) begin
            limit_n    = '0;
            top_type_n = 2'd0;
         end else begin
            limit_n    = top_frame.height;
            top_type_n = top_frame.ftype;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         depth           <= '0;
         status          <= ST_EMPTY;
         underflow_limit <= '0;
         top_type        <= 2'd0;
         target_valid    <= 1'b0;
         target_pc       <= '0;
         target_height   <= '0;
         target_arity    <= 1'b0;
         br_reg          <= '0;
         loop_reg        <= 1'b0;
      end else begin
         depth           <= depth_n;
         status          <= status_n;
         underflow_limit <= limit_n;
         top_type        <= top_type_n;
         target_valid    <= tvalid_n;
         target_pc       <= tpc_n;
         target_height   <= theight_n;
         target_arity    <= tarity_n;
         br_reg          <= br_reg_n;
         loop_reg        <= loop_reg_n;
      end
   end

   // Frame memory is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[depth[DEPTH-1:0]] <= wr_frame;
   end

endmodule

// File: tb/tb_control_frame_stack.sv
module tb_control_frame_stack;

   localparam int PC_W = 16;
   localparam int H_W  = 8;
   localparam int D    = 5;
   localparam int MAXF = 1 << D;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            op_valid = 1'b0;
   logic [1:0]      op = '0;
   logic [1:0]      frame_type = '0;
   logic [PC_W-1:0] frame_pc = '0;
   logic [H_W-1:0]  frame_height = '0;
   logic            frame_arity = 1'b0;
   logic [D-1:0]    br_depth = '0;
   logic            ready;
   logic [D:0]      depth;
   logic [H_W-1:0]  underflow_limit;
   logic [1:0]      top_type;
   logic            target_valid;
   logic [PC_W-1:0] target_pc;
   logic [H_W-1:0]  target_height;
   logic            target_arity;
   logic [2:0]      status;

   control_frame_stack #(.PC_WIDTH(PC_W), .HEIGHT_WIDTH(H_W), .DEPTH(D)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
      .frame_type(frame_type), .frame_pc(frame_pc), .frame_height(frame_height),
      .frame_arity(frame_arity), .br_depth(br_depth), .ready(ready), .depth(depth),
      .underflow_limit(underflow_limit), .top_type(top_type),
      .target_valid(target_valid), .target_pc(target_pc),
      .target_height(target_height), .target_arity(target_arity), .status(status)
   );

   // clock / reset
   always #5 clk = ~clk;

   // reference model: a plain list of frames, top at the back
   typedef struct {
      int ftype;
      int pc;
      int height;
      int arity;
   } frame_s;

   frame_s model[$];
   int     exp_status = 1;
   int     checks = 0;
   int     failures = 0;

   function automatic int status_for(input int n);
      if (n == MAXF) return 2;
      if (n == 0)    return 1;
      return 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      int n = model.size();
      check({tag, "_depth"}, 32'(depth), n);
      check({tag, "_status"}, 32'(status), exp_status);
      check({tag, "_limit"}, 32'(underflow_limit), (n == 0) ? 0 : model[n-1].height);
      check({tag, "_top_type"}, 32'(top_type), (n == 0) ? 0 : model[n-1].ftype);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_ready", 32'(ready), 1);
      check("rst_tvalid", 32'(target_valid), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model.delete();
      exp_status = 1;
   endtask

   // driver + model step: issues one op from IDLE and checks the outcome
   task automatic run_op(input string tag, input int o, input int ft, input int pc,
                         input int h, input int ar, input int br);
      frame_s f;
      int n = model.size();
      int keep;
      check({tag, "_ready_before"}, 32'(ready), 1);
      op_valid = 1'b1;
      op = 2'(o);
      frame_type = 2'(ft);
      frame_pc = PC_W'(pc);
      frame_height = H_W'(h);
      frame_arity = 1'(ar);
      br_depth = D'(br);
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      if (o == 0) begin
         exp_status = status_for(n);
         check({tag, "_tvalid"}, 32'(target_valid), 0);
         check_state(tag);
      end else if (o == 1) begin
         if (n == MAXF) exp_status = 4;
         else begin
            f = '{ft, pc, h, ar};
            model.push_back(f);
            exp_status = status_for(n + 1);
         end
         check({tag, "_tvalid"}, 32'(target_valid), 0);
         check_state(tag);
      end else if (o == 2) begin
         if (n == 0) begin
            exp_status = 3;
            check({tag, "_tvalid"}, 32'(target_valid), 0);
         end else begin
            f = model.pop_back();
            exp_status = status_for(n - 1);
            check({tag, "_tvalid"}, 32'(target_valid), 1);
            check({tag, "_tpc"}, 32'(target_pc), f.pc);
            check({tag, "_theight"}, 32'(target_height), f.height);
            check({tag, "_tarity"}, 32'(target_arity), f.arity);
         end
         check_state(tag);
      end else begin
         if (br >= n) begin
            exp_status = 5;
            check({tag, "_tvalid"}, 32'(target_valid), 0);
            check({tag, "_ready"}, 32'(ready), 1);
            check_state(tag);
         end else begin
            f = model[n-1-br];
            check({tag, "_tvalid"}, 32'(target_valid), 1);
            check({tag, "_ready_busy"}, 32'(ready), 0);
            check({tag, "_tpc"}, 32'(target_pc), f.pc);
            check({tag, "_theight"}, 32'(target_height), f.height);
            check({tag, "_tarity"}, 32'(target_arity), (f.ftype == 1) ? 0 : f.arity);
            keep = (f.ftype == 1) ? n - br : n - 1 - br;
            while (model.size() > keep) void'(model.pop_back());
            exp_status = status_for(keep);
            @(posedge clk);
            #1;
            check({tag, "_tvalid_end"}, 32'(target_valid), 0);
            check({tag, "_ready_end"}, 32'(ready), 1);
            check_state(tag);
         end
      end
   endtask

   initial begin
      frame_s f;
      int r;
      int n;
      int br;

      // asynchronous reset with no clock edge
      #3;
      reset = 1'b1;
      #1;
      check("async_ready", 32'(ready), 1);
      check("async_depth", 32'(depth), 0);
      check("async_status", 32'(status), 1);
      check("async_tvalid", 32'(target_valid), 0);
      check("async_limit", 32'(underflow_limit), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // fill to capacity, overflow, drain, underflow
      for (int i = 0; i < MAXF; i++) run_op("fill", 1, 0, 100 + i, i, i % 2, 0);
      check("full_depth", 32'(depth), 32);
      check("full_status", 32'(status), 2);
      check("full_limit", 32'(underflow_limit), 31);
      run_op("overflow", 1, 2, 16'h0bad, 77, 1, 0);
      check("overflow_status", 32'(status), 4);
      check("overflow_depth", 32'(depth), 32);
      run_op("none_full", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < MAXF; i++) run_op("drain", 2, 0, 0, 0, 0, 0);
      run_op("underflow", 2, 0, 0, 0, 0, 0);
      check("underflow_status", 32'(status), 3);

      // branch to block, with a bad offset first
      do_reset();
      run_op("blk_push0", 1, 0, 16'h40, 3, 1, 0);
      run_op("blk_push1", 1, 1, 16'h10, 5, 1, 0);
      run_op("blk_push2", 1, 0, 16'h80, 7, 0, 0);
      run_op("bad_offset", 3, 0, 0, 0, 0, 3);
      check("bad_offset_status", 32'(status), 5);
      run_op("br_block", 3, 0, 0, 0, 0, 2);
      check("br_block_depth", 32'(depth), 0);
      check("br_block_status", 32'(status), 1);

      // branch to loop
      do_reset();
      run_op("loop_push0", 1, 0, 16'h40, 3, 1, 0);
      run_op("loop_push1", 1, 1, 16'h10, 5, 1, 0);
      run_op("loop_push2", 1, 0, 16'h80, 7, 0, 0);
      run_op("br_loop", 3, 0, 0, 0, 0, 1);
      check("br_loop_depth", 32'(depth), 2);
      check("br_loop_limit", 32'(underflow_limit), 5);
      check("br_loop_top", 32'(top_type), 1);

      // PUSH held while a BRANCH resolves is taken only once ready returns
      op_valid = 1'b1;
      op = 2'd3;
      br_depth = '0;
      @(posedge clk);
      #1;
      check("hold_tvalid", 32'(target_valid), 1);
      check("hold_tpc", 32'(target_pc), 32'h10);
      check("hold_tarity", 32'(target_arity), 0);
      check("hold_ready", 32'(ready), 0);
      op = 2'd1;
      frame_type = 2'd2;
      frame_pc = 16'h99;
      frame_height = 8'd9;
      frame_arity = 1'b0;
      @(posedge clk);
      #1;
      check("hold_ignored_depth", 32'(depth), 2);
      check("hold_ready_back", 32'(ready), 1);
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      f = '{2, 16'h99, 9, 0};
      model.push_back(f);
      exp_status = 0;
      check_state("hold_accepted");

      // return through a CALL frame
      do_reset();
      run_op("call_push", 1, 3, 16'h1234, 2, 1, 0);
      run_op("call_pop", 2, 0, 0, 0, 0, 0);

      // reset during RESOLVE aborts the branch
      run_op("abort_push0", 1, 0, 16'h200, 4, 1, 0);
      run_op("abort_push1", 1, 2, 16'h300, 6, 0, 0);
      op_valid = 1'b1;
      op = 2'd3;
      br_depth = 5'd1;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      check("abort_in_resolve", 32'(ready), 0);
      reset = 1'b1;
      #1;
      check("abort_tvalid", 32'(target_valid), 0);
      check("abort_depth", 32'(depth), 0);
      check("abort_ready", 32'(ready), 1);
      check("abort_status", 32'(status), 1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model.delete();
      exp_status = 1;
      @(posedge clk);
      #1;
      check("abort_no_pulse", 32'(target_valid), 0);
      check_state("abort_after");

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 500; i++) begin
         n = model.size();
         r = $urandom_range(0, 9);
         br = $urandom_range(0, n + 1);
         if (br > MAXF - 1) br = MAXF - 1;
         if (r < 4)
            run_op("rnd_push", 1, $urandom_range(0, 3), $urandom_range(0, 16'hffff),
                   $urandom_range(0, 255), $urandom_range(0, 1), 0);
         else if (r < 6)
            run_op("rnd_pop", 2, 0, 0, 0, 0, 0);
         else if (r < 9)
            run_op("rnd_branch", 3, 0, 0, 0, 0, br);
         else
            run_op("rnd_none", 0, 0, 0, 0, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
